// File: rtl/pcie_out_arbiter.sv
// Packet-granularity round-robin arbiter sharing one PCIe output channel among N_REQ requesters.
// Optional mid-packet starvation watchdog enabled by defining PCIE_ARB_WATCHDOG_EN.
module pcie_out_arbiter #(
  parameter int WIDTH       = 64,
  parameter int N_REQ       = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]     i_req_bits,
  input  logic [N_REQ-1:0]           i_req_last,
  output logic                       o_pcie_out_valid,
  input  logic                       i_pcie_out_ready,
  output logic [WIDTH-1:0]           o_pcie_out_bits,
  output logic                       o_pcie_out_last,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_busy,
  output logic                       o_wdog_err
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  if (N_REQ < 2) begin : g_chk_nreq
    $error("pcie_out_arbiter: N_REQ must be at least 2");
  end
  if (WDOG_CYCLES < 1) begin : g_chk_wdog
    $error("pcie_out_arbiter: WDOG_CYCLES must be at least 1");
  end

  logic [0:0]       r_state;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    r_rr_ptr;
  logic [GW-1:0]    w_sel;
  logic [GW-1:0]    w_idx;
  logic             w_busy;
  logic             w_valid_g;
  logic             w_last_g;
  logic [WIDTH-1:0] w_bits_g;
  logic             w_done;
  logic             w_abort;

  assign w_busy = (r_state == ST_BUSY);

  // Search from rr_ptr+1 with wrap; walking farthest-to-nearest lets the nearest hit win.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % N_REQ);
      if (i_req_valid[w_idx]) w_sel = w_idx;
    end
  end

  always_comb begin
    w_valid_g   = 1'b0;
    w_last_g    = 1'b0;
    w_bits_g    = '0;
    o_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_valid_g = i_req_valid[i];
        w_last_g  = i_req_last[i];
        w_bits_g  = i_req_bits[i*WIDTH +: WIDTH];
        o_req_ready[i] = w_busy & i_pcie_out_ready;
      end
    end
  end

  assign o_pcie_out_valid = w_busy & w_valid_g;
  assign o_pcie_out_last  = w_busy & w_last_g;
  assign o_pcie_out_bits  = w_busy ? w_bits_g : '0;
  assign o_grant_id       = r_grant;
  assign o_busy           = w_busy;
  assign w_done           = o_pcie_out_valid & i_pcie_out_ready & o_pcie_out_last;

`ifdef PCIE_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] r_wdog_cnt;
  logic          r_wdog_err;

  assign w_abort    = w_busy & ~w_done & (r_wdog_cnt == CW'(WDOG_CYCLES));
  assign o_wdog_err = r_wdog_err;

  // Only an absent requester counts; downstream backpressure never does.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (!w_busy || w_valid_g)
        r_wdog_cnt <= '0;
      else if (r_wdog_cnt != CW'(WDOG_CYCLES))
        r_wdog_cnt <= r_wdog_cnt + CW'(1);
      if (w_abort) r_wdog_err <= 1'b1;
    end
  end
`else
  assign w_abort    = 1'b0;
  assign o_wdog_err = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= GW'(N_REQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_req_valid) begin
            r_grant <= w_sel;
            r_state <= ST_BUSY;
          end
        end
        default: begin
          if (w_done || w_abort) begin
            r_rr_ptr <= r_grant;
            r_state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/pcie_out_arbiter.md
# pcie_out_arbiter

Packet-granularity round-robin arbiter that shares the single shim PCIe output channel (`io_pcie_out_*`) among N_REQ host-bound requesters, for example MMIO read responses, DMA completions and trace streams. Each requester presents multi-beat packets marked by a `last` bit. The arbiter grants one requester at a time and holds the grant until that packet's last beat is accepted, so packets never interleave on the link. It sits between the requester FIFOs and the CatapultShim `io_pcie_out` port.

## Interface

- WIDTH, 64, beat width; equals `PCIE_WIDTH`
- N_REQ, 4, number of requesters; must be at least 2
- WDOG_CYCLES, 1024, mid-packet starvation limit; used only with the watchdog enabled (must be at least 1)

- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  per-requester beat valid
- req_ready  out  N_REQ  per-requester beat accept
- req_bits  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  in  N_REQ  beat is the final beat of its packet
- pcie_out_valid  out  1  beat valid toward the shim
- pcie_out_ready  in  1  shim accepts the beat
- pcie_out_bits  out  WIDTH  beat data
- pcie_out_last  out  1  final beat of the packet
- grant_id  out  $clog2(N_REQ)  current or most recent grantee
- busy  out  1  high while in the BUSY state
- wdog_err  out  1  sticky watchdog abort flag

## Operation

- FSM has two states, IDLE and BUSY; reset state is IDLE.
- **IDLE**
  - All `req_ready` are 0 and `pcie_out_valid` = 0.
  - If any `req_valid` is high, select the first requester with valid high, searching from index `rr_ptr+1` upward with wrap-around.
  - Register the selection into `grant_id` and move to BUSY.
  - `req_last` is not sampled in IDLE.
- **BUSY** (g = `grant_id`)
  - `pcie_out_valid` = `req_valid[g]`, `pcie_out_bits` = `req_bits[g]`, `pcie_out_last` = `req_last[g]`.
  - `req_ready[g]` = `pcie_out_ready`; every other `req_ready` bit is 0.
  - These are combinational pass-through paths; there is no data register.
  - A handshake (`pcie_out_valid & pcie_out_ready`) with `pcie_out_last` = 1 sets `rr_ptr` to g and moves to IDLE.
- Requesters that assert valid during BUSY wait; no packet is ever interleaved with another.
- A requester that drops `req_valid` mid-packet keeps the grant; the link stalls.
- A single-beat packet (last = 1 on the first beat) is legal.
- `rr_ptr` resets to N_REQ-1, so requester 0 has first priority after reset.

## Timing

- Reset values: `req_ready` = 0, `pcie_out_valid` = 0, `pcie_out_last` = 0, `pcie_out_bits` = 0, `grant_id` = 0, `busy` = 0, `wdog_err` = 0.
- Arbitration latency: a request seen in IDLE at cycle t produces `pcie_out_valid` at cycle t+1, provided `req_valid` is still high.
- Back-to-back packets have exactly one idle cycle between the last beat of one and the first beat of the next, including when the same requester continues.
- Throughput in BUSY is one beat per cycle while `req_valid[g]` and `pcie_out_ready` are both high.
- Reset asserted mid-packet returns the FSM to IDLE immediately (asynchronously). `pcie_out_valid` drops in the same cycle, and the truncated packet is the shim's concern.
- With a single active requester, every packet is granted to that requester.

## Configuration

- Macro: `PCIE_ARB_WATCHDOG_EN`.
- **Defined**
  - In BUSY, a counter increments on each cycle with `req_valid[g]` = 0 and clears on any cycle with `req_valid[g]` = 1.
  - Counter width is $clog2(WDOG_CYCLES+1).
  - When the count reaches WDOG_CYCLES, the arbiter aborts the packet:
    - sets `wdog_err`, which stays set until reset;
    - sets `rr_ptr` to g;
    - returns to IDLE on the next edge.
  - Stalls caused by `pcie_out_ready` = 0 with `req_valid[g]` = 1 never count.
  - The counter clears on entry to BUSY.
- **Undefined**
  - No counter is built and `wdog_err` is tied to 0.
  - The grant is held indefinitely until the last beat is accepted.

## Test plan

- **Reset:** after reset deassertion with all inputs 0 → all outputs 0; a request asserted mid-packet followed by a reset pulse → `busy` = 0 and `pcie_out_valid` = 0 in the same cycle.
- **Round-robin:** all four requesters continuously offer 2-beat packets with `pcie_out_ready` = 1 → grant order 0,1,2,3,0,…; each packet is 2 beats followed by 1 idle cycle.
- **No interleave under backpressure:** requester 2 sends a 3-beat packet (A,B,C) with `pcie_out_ready` toggling 1,0,1,0,…, while requester 0 raises valid mid-packet → output is A,B,C from requester 2, then one idle cycle, then requester 0's packet.
- **Single-beat and same-requester repeat:** only requester 1 sends three 1-beat packets → `grant_id` = 1 each time; beats are spaced by 1 idle cycle; `pcie_out_last` = 1 on every beat.
- **Watchdog** (`PCIE_ARB_WATCHDOG_EN`, WDOG_CYCLES = 8):
  - Requester 3 sends 1 beat without last, then holds valid = 0 for 8 cycles → `wdog_err` = 1, the FSM returns to IDLE, and requester 0 is granted next.
  - Same stimulus without the macro → the grant to requester 3 is held and `wdog_err` = 0.
- **Downstream stall is not starvation** (watchdog enabled): requester 0 keeps valid = 1 while `pcie_out_ready` = 0 for 20 cycles → `wdog_err` stays 0, and the packet completes once ready returns.
